cc_sched: RTL and testbench

Sequential controller for the combinational CC compute datapath. It collects one job of six 4-bit operands plus mode bits over a six-beat input burst. It holds those operands and mode bits stable on the datapath ports, samples the 10-bit datapath result after a fixed settle window, and returns it with a one-cycle valid pulse. The block sits between the lab pattern interface and the CC instance; the CC instance is instantiated beside it, not inside it.

---
 rtl/cc_sched.sv | 197 +++++++++++++++++++
 tb/tb_cc_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_sched.sv
// cc_sched: sequential controller for the combinational CC datapath.
// Collects a six-beat operand burst, holds the operands on the dp_* ports,
// samples dp_out after a settle window and returns it with a one-cycle strobe.
// Build option: define CC_SCHED_MC2_EN to stretch the settle window to two
// cycles (datapath treated as a 2-cycle multicycle path).
module cc_sched #(
    parameter int unsigned NBEAT = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_n,
    input  logic [2:0] opt,
    input  logic       equ,
    output logic [3:0] dp_n0,
    output logic [3:0] dp_n1,
    output logic [3:0] dp_n2,
    output logic [3:0] dp_n3,
    output logic [3:0] dp_n4,
    output logic [3:0] dp_n5,
    output logic [2:0] dp_opt,
    output logic       dp_equ,
    input  logic [9:0] dp_out,
    output logic       out_valid,
    output logic [9:0] out_n,
    output logic       busy,
    output logic       err
);

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned OPT_W  = 3;
    localparam int unsigned RES_W  = 10;
    localparam int unsigned BEAT_W = 3;
    localparam int unsigned WAIT_W = 1;
    localparam int unsigned ST_W   = 2;

`ifdef CC_SCHED_MC2_EN
    localparam int unsigned EXEC_CYC = 2;
`else
    localparam int unsigned EXEC_CYC = 1;
`endif

    localparam logic [ST_W-1:0] S_IDLE = 2'd0;
    localparam logic [ST_W-1:0] S_LOAD = 2'd1;
    localparam logic [ST_W-1:0] S_EXEC = 2'd2;
    localparam logic [ST_W-1:0] S_OUT  = 2'd3;

    logic [ST_W-1:0]   r_state;
    logic [BEAT_W-1:0] r_beat;
    logic [WAIT_W-1:0] r_wait;
    logic [NIB_W-1:0]  r_op [NBEAT];
    logic [OPT_W-1:0]  r_opt;
    logic              r_equ;
    logic [RES_W-1:0]  r_out_n;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_err;

    logic [ST_W-1:0]   w_state_nxt;
    logic [BEAT_W-1:0] w_beat_nxt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_cap;
    logic [BEAT_W-1:0] w_cap_idx;
    logic              w_cap_mode;
    logic [RES_W-1:0]  w_out_n_nxt;
    logic              w_out_valid_nxt;
    logic              w_busy_nxt;
    logic              w_err_nxt;

    // Next-state, capture control and next output values.
    always_comb begin
        w_state_nxt     = r_state;
        w_beat_nxt      = r_beat;
        w_wait_nxt      = r_wait;
        w_cap           = 1'b0;
        w_cap_idx       = '0;
        w_cap_mode      = 1'b0;
        w_out_n_nxt     = '0;
        w_out_valid_nxt = 1'b0;
        w_err_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_cap       = 1'b1;
                    w_cap_idx   = '0;
                    w_cap_mode  = 1'b1;
                    w_beat_nxt  = BEAT_W'(1);
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    w_cap     = 1'b1;
                    w_cap_idx = r_beat;
                    if (r_beat == BEAT_W'(NBEAT - 1)) begin
                        w_beat_nxt  = '0;
                        w_wait_nxt  = '0;
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_beat_nxt = r_beat + BEAT_W'(1);
                    end
                end else begin
                    // Burst dropped early: flag it and discard the job.
                    w_err_nxt   = 1'b1;
                    w_beat_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_EXEC: begin
                // in_valid is ignored here; operands stay frozen on dp_*.
                if (r_wait == WAIT_W'(EXEC_CYC - 1)) begin
                    w_out_n_nxt     = dp_out;
                    w_out_valid_nxt = 1'b1;
                    w_wait_nxt      = '0;
                    w_state_nxt     = S_OUT;
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end
            S_OUT: begin
                // A beat here is beat 0 of the next job, so back-to-back
                // jobs overlap the result cycle with the first beat.
                if (in_valid) begin
                    w_cap       = 1'b1;
                    w_cap_idx   = '0;
                    w_cap_mode  = 1'b1;
                    w_beat_nxt  = BEAT_W'(1);
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_LOAD) || (w_state_nxt == S_EXEC);
    end

    // FSM state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Operand/mode capture and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NBEAT; k++) begin
                r_op[k] <= '0;
            end
            r_opt       <= '0;
            r_equ       <= 1'b0;
            r_out_n     <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            for (int k = 0; k < NBEAT; k++) begin
                if (w_cap && (w_cap_idx == BEAT_W'(k))) begin
                    r_op[k] <= in_n;
                end
            end
            if (w_cap_mode) begin
                r_opt <= opt;
                r_equ <= equ;
            end
            r_out_n     <= w_out_n_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign dp_n0     = r_op[0];
    assign dp_n1     = r_op[1];
    assign dp_n2     = r_op[2];
    assign dp_n3     = r_op[3];
    assign dp_n4     = r_op[4];
    assign dp_n5     = r_op[5];
    assign dp_opt    = r_opt;
    assign dp_equ    = r_equ;
    assign out_n     = r_out_n;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_cc_sched.sv
// Bench for cc_sched with a stand-in combinational datapath on dp_*.
// Honours CC_SCHED_MC2_EN for the settle window length.
module tb_cc_sched;

`ifdef CC_SCHED_MC2_EN
    localparam int EX = 2;
`else
    localparam int EX = 1;
`endif
    localparam int LAT = 6 + EX;
    localparam int NC  = 1200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_n = 4'd0;
    logic [2:0] opt = 3'd0;
    logic       equ = 1'b0;
    logic [3:0] dp_n0, dp_n1, dp_n2, dp_n3, dp_n4, dp_n5;
    logic [2:0] dp_opt;
    logic       dp_equ;
    logic [9:0] dp_out;
    logic       out_valid;
    logic [9:0] out_n;
    logic       busy;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_out = 0;
    int first_out = 0;

    typedef struct {
        logic [2:0]      opt;
        logic            equ;
        logic [5:0][3:0] n;
        logic [9:0]      exp;
    } rec_t;

    rec_t tbl [6];

    // Randomized stimulus and model expectations, indexed by cycle.
    logic        s_iv  [NC];
    logic [3:0]  s_in  [NC];
    logic [2:0]  s_opt [NC];
    logic        s_eq  [NC];
    logic        e_ov  [NC];
    logic [9:0]  e_on  [NC];
    logic        e_bsy [NC];
    logic        e_err [NC];
    logic        e_dpc [NC];
    logic [27:0] e_dp  [NC];

    cc_sched #(.NBEAT(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_n(in_n),
        .opt(opt), .equ(equ),
        .dp_n0(dp_n0), .dp_n1(dp_n1), .dp_n2(dp_n2), .dp_n3(dp_n3),
        .dp_n4(dp_n4), .dp_n5(dp_n5), .dp_opt(dp_opt), .dp_equ(dp_equ),
        .dp_out(dp_out), .out_valid(out_valid), .out_n(out_n),
        .busy(busy), .err(err)
    );

    // Stand-in datapath: equ=1 alternating sum, equ=0 weighted sum, opt flips top bits.
    function automatic logic [9:0] cc_dp(input logic [3:0] a0, a1, a2, a3, a4, a5,
                                         input logic [2:0] o, input logic e);
        int s;
        if (e) s = int'(a0) + int'(a1) - int'(a2) + int'(a3) - int'(a4) + int'(a5);
        else   s = int'(a0) + int'(a1) + int'(a2) + int'(a3) + 3 * int'(a4) + int'(a5);
        return 10'(s) ^ {o, 7'b0};
    endfunction

    assign dp_out = cc_dp(dp_n0, dp_n1, dp_n2, dp_n3, dp_n4, dp_n5, dp_opt, dp_equ);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_out();
        return 64'({dp_n0, dp_n1, dp_n2, dp_n3, dp_n4, dp_n5, dp_opt, dp_equ,
                    out_n, out_valid, busy, err});
    endfunction

    function automatic logic [27:0] dp_pack();
        return {dp_n5, dp_n4, dp_n3, dp_n2, dp_n1, dp_n0, dp_opt, dp_equ};
    endfunction

    function automatic rec_t mk(input logic [2:0] o, input logic e,
                                input logic [23:0] n, input logic [9:0] x);
        rec_t r;
        r.opt = o;
        r.equ = e;
        r.n   = n;
        r.exp = x;
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One job starting this cycle; ends in its result cycle with in_valid low.
    task automatic run_job(input rec_t r);
        for (int k = 0; k <= LAT; k++) begin
            if (k > 0) begin
                chk("job_busy", 64'(busy), 64'(k < LAT));
                chk("job_out_valid", 64'(out_valid), 64'(k == LAT));
                chk("job_out_n", 64'(out_n), 64'((k == LAT) ? r.exp : 10'd0));
                chk("job_err", 64'(err), 64'd0);
                if (k >= 6) chk("job_dp_hold", 64'(dp_pack()), 64'({r.n, r.opt, r.equ}));
                if (k == LAT) last_out = cyc;
            end
            if (k < 6) begin
                in_valid = 1'b1;
                in_n     = r.n[k];
            end else begin
                in_valid = 1'b0;
                in_n     = 4'($urandom);
            end
            opt = (k == 0) ? r.opt : 3'($urandom);
            equ = (k == 0) ? r.equ : 1'($urandom);
            if (k < LAT) tick();
        end
    endtask

    initial begin
        int c, s, L, o, a, gap, kind, len;

        tbl[0] = mk(3'b000, 1'b1, 24'h654321, 10'd5);
        tbl[1] = mk(3'b000, 1'b0, 24'h654321, 10'd31);
        tbl[2] = mk(3'b101, 1'b0, 24'hFFFFFF, 10'h2F8);
        tbl[3] = mk(3'b000, 1'b1, 24'h000F00, 10'h3F1);
        tbl[4] = mk(3'b111, 1'b1, 24'hF0F0FF, 10'h3BC);
        tbl[5] = mk(3'b010, 1'b0, 24'h812709, 10'h11D);

        // Reset state.
        do_reset();
        chk("reset_outputs", all_out(), 64'd0);

        // Directed jobs with an idle cycle between them.
        for (int i = 0; i < 6; i++) begin
            run_job(tbl[i]);
            tick();
        end

        // Back-to-back: second job's beat 0 lands in the first job's result cycle.
        run_job(tbl[0]);
        first_out = last_out;
        run_job(tbl[1]);
        chk("b2b_spacing", 64'(last_out - first_out), 64'(6 + EX));
        tick();

        // Burst aborted after 3 beats.
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                chk("abort_busy", 64'(busy), 64'(k <= 3));
                chk("abort_err", 64'(err), 64'(k == 4));
                chk("abort_out_valid", 64'(out_valid), 64'd0);
            end
            in_valid = (k < 3);
            in_n     = 4'($urandom);
            opt      = 3'($urandom);
            equ      = 1'($urandom);
            tick();
        end
        run_job(tbl[2]);
        tick();

        // Reset asserted during beat 4.
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_n     = 4'(k + 9);
            opt      = 3'b011;
            equ      = 1'b1;
            tick();
        end
        in_valid = 1'b1;
        in_n     = 4'd7;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", all_out(), 64'd0);
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("postreset_quiet", 64'({out_valid, err, busy}), 64'd0);
        end
        run_job(tbl[4]);
        tick();

        // Randomized stimulus against a timeline model.
        for (int i = 0; i < NC; i++) begin
            s_iv[i]  = 1'b0;
            s_in[i]  = 4'($urandom);
            s_opt[i] = 3'($urandom);
            s_eq[i]  = 1'($urandom);
            e_ov[i]  = 1'b0;
            e_on[i]  = 10'd0;
            e_bsy[i] = 1'b0;
            e_err[i] = 1'b0;
            e_dpc[i] = 1'b0;
            e_dp[i]  = 28'd0;
        end
        c = 0;
        while (c < NC - 24) begin
            gap  = int'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 9));
            repeat (gap) begin s_iv[c] = 1'b0; c++; end
            if (kind < 6)      len = 6;
            else if (kind < 7) len = 6 + int'($urandom_range(1, 2));
            else               len = int'($urandom_range(1, 5));
            repeat (len) begin s_iv[c] = 1'b1; c++; end
            if (kind >= 7) begin s_iv[c] = 1'b0; c++; end
        end

        // A job starts at the first strobe once the block is free; six
        // consecutive strobes complete it, fewer abort it.
        s = 0;
        forever begin
            while (s < NC && !s_iv[s]) s++;
            if (s >= NC) break;
            L = 0;
            while (L < 6 && s_iv[s + L]) L++;
            if (L == 6) begin
                o = s + 6 + EX;
                if (o >= NC) break;
                for (int t = s + 1; t < o; t++) e_bsy[t] = 1'b1;
                e_ov[o] = 1'b1;
                e_on[o] = cc_dp(s_in[s], s_in[s+1], s_in[s+2], s_in[s+3], s_in[s+4],
                                s_in[s+5], s_opt[s], s_eq[s]);
                for (int t = s + 6; t <= o; t++) begin
                    e_dpc[t] = 1'b1;
                    e_dp[t]  = {s_in[s+5], s_in[s+4], s_in[s+3], s_in[s+2], s_in[s+1],
                                s_in[s], s_opt[s], s_eq[s]};
                end
                s = o;
            end else begin
                a = s + L;
                if (a + 1 >= NC) break;
                for (int t = s + 1; t <= a; t++) e_bsy[t] = 1'b1;
                e_err[a + 1] = 1'b1;
                s = a + 1;
            end
        end

        do_reset();
        for (int t = 0; t < NC; t++) begin
            chk("rnd_out_valid", 64'(out_valid), 64'(e_ov[t]));
            chk("rnd_out_n", 64'(out_n), 64'(e_on[t]));
            chk("rnd_busy", 64'(busy), 64'(e_bsy[t]));
            chk("rnd_err", 64'(err), 64'(e_err[t]));
            if (e_dpc[t]) chk("rnd_dp", 64'(dp_pack()), 64'(e_dp[t]));
            in_valid = s_iv[t];
            in_n     = s_in[t];
            opt      = s_opt[t];
            equ      = s_eq[t];
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
